// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-programmable pattern and length.
// Registered one-cycle match pulse, saturating match counter and history fill level.
module seq_detector_param #(
    parameter int                 MAX_LEN = 8,
    parameter int                 CNT_W   = 8,
    parameter bit                 OVERLAP = 1'b1,
    parameter logic [MAX_LEN-1:0] PAT_RST = 8'h05,
    parameter int                 LEN_RST = 3,
    localparam int                LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               din_valid,
    input  logic               din,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               clr_count,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic [LEN_W-1:0]   fill,
    output logic               cfg_err
);

    localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_RST_C = LEN_W'(LEN_RST);
    localparam logic [LEN_W:0]   FILL_ONE  = (LEN_W + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               match_q, match_d;
    logic               err_q, err_d;

    logic [MAX_LEN-1:0] new_hist;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W:0]     fill_inc;
    logic [CNT_W-1:0]   cnt_base;
    logic               accept;
    logic               cfg_ok;
    logic               hit;

    // Only the low len_q bits of the window take part in the compare.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_q));
        end
    end

    always_comb begin
        accept   = din_valid && !cfg_load;
        cfg_ok   = (cfg_len != '0) && (cfg_len <= MAX_LEN_C);
        new_hist = {hist_q[MAX_LEN-2:0], din};
        fill_inc = {1'b0, fill_q} + FILL_ONE;
        hit      = accept
                && (fill_inc >= {1'b0, len_q})
                && (((new_hist ^ pat_q) & mask) == '0);
    end

    always_comb begin
        pat_d   = pat_q;
        len_d   = len_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        err_d   = 1'b0;
        match_d = hit;
        if (cfg_load) begin
            if (cfg_ok) begin
                pat_d  = cfg_pattern;
                len_d  = cfg_len;
                hist_d = '0;
                fill_d = '0;
            end else begin
                err_d = 1'b1;
            end
        end else if (din_valid) begin
            hist_d = new_hist;
            if (hit && !OVERLAP) begin
                fill_d = '0;
            end else if (fill_inc > {1'b0, len_q}) begin
                fill_d = len_q;
            end else begin
                fill_d = fill_inc[LEN_W-1:0];
            end
        end
    end

    // Clear applies first so a match on the clear edge still counts.
    always_comb begin
        cnt_base = clr_count ? '0 : cnt_q;
        cnt_d    = cnt_base;
        if (hit && (cnt_base != '1)) begin
            cnt_d = cnt_base + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q   <= PAT_RST;
            len_q   <= LEN_RST_C;
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            len_q   <= len_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            err_q   <= err_d;
        end
    end

    assign match       = match_q;
    assign match_count = cnt_q;
    assign fill        = fill_q;
    assign cfg_err     = err_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: overlapping, non-overlapping and narrow-counter
// instances share one stimulus bus; expected match bits go through a queue.
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               din_valid = 1'b0;
    logic               din = 1'b0;
    logic               cfg_load = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               clr_count = 1'b0;

    logic               m0, m1, m2;
    logic [7:0]         c0, c1;
    logic [1:0]         c2;
    logic [LEN_W-1:0]   f0, f1, f2;
    logic               e0, e1, e2;

    int passed = 0;
    int total  = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    seq_detector_param u_ovl (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .clr_count(clr_count), .match(m0), .match_count(c0),
        .fill(f0), .cfg_err(e0)
    );

    seq_detector_param #(.OVERLAP(1'b0)) u_nov (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .clr_count(clr_count), .match(m1), .match_count(c1),
        .fill(f1), .cfg_err(e1)
    );

    seq_detector_param #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .clr_count(clr_count), .match(m2), .match_count(c2),
        .fill(f2), .cfg_err(e2)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    task automatic do_reset();
        din_valid = 1'b0;
        din       = 1'b0;
        cfg_load  = 1'b0;
        clr_count = 1'b0;
        rst       = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic step(input logic v, input logic d, input logic e);
        din_valid = v;
        din       = d;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({m0, c0, f0, e0} !== 14'd0) begin
            $display("FAIL reset_outputs: got %h want 0", {m0, c0, f0, e0});
        end else passed++;
    endtask

    task automatic test_overlap();
        logic [4:0] bits = 5'b10101;
        logic [4:0] exp  = 5'b00101;
        int         fexp[5] = '{1, 2, 3, 3, 3};
        logic       e;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, bits[4-i], exp[4-i]);
            e = exp_q.pop_front();
            total++;
            if (m0 !== e) begin
                $display("FAIL ovl_match[%0d]: got %b want %b", i, m0, e);
            end else passed++;
            total++;
            if (int'(f0) !== fexp[i]) begin
                $display("FAIL ovl_fill[%0d]: got %0d want %0d", i, f0, fexp[i]);
            end else passed++;
        end
        din_valid = 1'b0;
        total++;
        if (c0 !== 8'd2) begin
            $display("FAIL ovl_count: got %0d want 2", c0);
        end else passed++;
    endtask

    task automatic test_no_overlap();
        logic [6:0] bits = 7'b1010101;
        logic [6:0] exp  = 7'b0010001;
        int         fexp[7] = '{1, 2, 0, 1, 2, 3, 0};
        logic       e;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(1'b1, bits[6-i], exp[6-i]);
            e = exp_q.pop_front();
            total++;
            if (m1 !== e) begin
                $display("FAIL nov_match[%0d]: got %b want %b", i, m1, e);
            end else passed++;
            total++;
            if (int'(f1) !== fexp[i]) begin
                $display("FAIL nov_fill[%0d]: got %0d want %0d", i, f1, fexp[i]);
            end else passed++;
        end
        din_valid = 1'b0;
        total++;
        if (c1 !== 8'd2) begin
            $display("FAIL nov_count: got %0d want 2", c1);
        end else passed++;
    endtask

    task automatic test_cfg_gaps();
        logic e;
        do_reset();
        cfg_load    = 1'b1;
        cfg_pattern = 8'h0F;
        cfg_len     = 4'd4;
        step(1'b1, 1'b1, 1'b0);
        e = exp_q.pop_front();
        cfg_load = 1'b0;
        total++;
        if ({m0, e0, f0} !== {e, 1'b0, 4'd0}) begin
            $display("FAIL cfg_load_ok: got m=%b err=%b fill=%0d want m=%b err=0 fill=0",
                     m0, e0, f0, e);
        end else passed++;
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b1, k >= 3);
            e = exp_q.pop_front();
            total++;
            if (m0 !== e) begin
                $display("FAIL gap_match[%0d]: got %b want %b", k, m0, e);
            end else passed++;
            step(1'b0, 1'b0, 1'b0);
            e = exp_q.pop_front();
            total++;
            if (m0 !== e) begin
                $display("FAIL gap_idle[%0d]: got %b want %b", k, m0, e);
            end else passed++;
        end
        total++;
        if (c0 !== 8'd3) begin
            $display("FAIL gap_count: got %0d want 3", c0);
        end else passed++;
        total++;
        if (f0 !== 4'd4) begin
            $display("FAIL gap_fill: got %0d want 4", f0);
        end else passed++;
    endtask

    task automatic test_cfg_err();
        logic [3:0] bad[2] = '{4'd0, 4'd9};
        logic [2:0] bits = 3'b101;
        logic [2:0] exp  = 3'b001;
        logic       e;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            cfg_load    = 1'b1;
            cfg_pattern = 8'hFF;
            cfg_len     = bad[i];
            step(1'b1, 1'b1, 1'b0);
            e = exp_q.pop_front();
            total++;
            if ({m0, e0, f0} !== {e, 1'b1, 4'd0}) begin
                $display("FAIL cfg_err[%0d]: got m=%b err=%b fill=%0d want m=%b err=1 fill=0",
                         i, m0, e0, f0, e);
            end else passed++;
        end
        cfg_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, bits[2-i], exp[2-i]);
            e = exp_q.pop_front();
            total++;
            if ({m0, e0} !== {e, 1'b0}) begin
                $display("FAIL err_default[%0d]: got m=%b err=%b want m=%b err=0",
                         i, m0, e0, e);
            end else passed++;
        end
        din_valid = 1'b0;
        total++;
        if (c0 !== 8'd1) begin
            $display("FAIL err_count: got %0d want 1", c0);
        end else passed++;
    endtask

    task automatic test_saturate();
        logic e;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            step(1'b1, (i % 2) == 0, (i >= 2) && ((i % 2) == 0));
            e = exp_q.pop_front();
            total++;
            if (m2 !== e) begin
                $display("FAIL sat_match[%0d]: got %b want %b", i, m2, e);
            end else passed++;
        end
        total++;
        if (c2 !== 2'd3) begin
            $display("FAIL sat_count: got %0d want 3", c2);
        end else passed++;
        step(1'b1, 1'b0, 1'b0);
        e = exp_q.pop_front();
        clr_count = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        e = exp_q.pop_front();
        clr_count = 1'b0;
        din_valid = 1'b0;
        total++;
        if ({m2, c2} !== {e, 2'd1}) begin
            $display("FAIL clr_with_match: got m=%b cnt=%0d want m=%b cnt=1", m2, c2, e);
        end else passed++;
        total++;
        if (c0 !== 8'd1) begin
            $display("FAIL clr_wide: got %0d want 1", c0);
        end else passed++;
    endtask

    task automatic test_mid_reset();
        logic e;
        step(1'b1, 1'b1, 1'b0);
        e = exp_q.pop_front();
        step(1'b1, 1'b0, 1'b0);
        e = exp_q.pop_front();
        din_valid = 1'b0;
        total++;
        if ({m0, f0} !== {e, 4'd3}) begin
            $display("FAIL pre_reset: got m=%b fill=%0d want m=%b fill=3", m0, f0, e);
        end else passed++;
        #3;
        rst = 1'b0;
        #1;
        total++;
        if ({m0, c0, f0, e0, c2, f2} !== 20'd0) begin
            $display("FAIL async_reset: got %h want 0", {m0, c0, f0, e0, c2, f2});
        end else passed++;
        #1;
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        e = exp_q.pop_front();
        din_valid = 1'b0;
        total++;
        if ({m0, f0} !== {e, 4'd1}) begin
            $display("FAIL post_reset: got m=%b fill=%0d want m=%b fill=1", m0, f0, e);
        end else passed++;
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_no_overlap();
        test_cfg_gaps();
        test_cfg_err();
        test_saturate();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
